store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 23 ++
 rtl/store_buffer_fifo.sv | 65 ++++++
 rtl/store_buffer.sv | 148 ++++++++++++++
 tb/tb_store_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
package store_buffer_pkg;

    localparam int unsigned DefaultDepth = 4;

    localparam logic [2:0] SzByte = 3'b001;
    localparam logic [2:0] SzHalf = 3'b011;
    localparam logic [2:0] SzWord = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StDrainWait,
        StLoadWait,
        StLoadDone
    } sb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Pending-store storage: circular FIFO with a parallel word-address compare that
// reports whether any valid entry matches and the index of the youngest match.
module store_buffer_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  sb_entry_t       push_entry,
    input  logic            pop,
    output sb_entry_t       head_entry,
    output logic            full,
    output logic            empty,
    input  logic [29:0]     cmp_word,
    output logic            hit,
    output logic [PtrW-1:0] hit_idx,
    output sb_entry_t       hit_entry
);

    sb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) count_q <= count_q + (PtrW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [PtrW-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PtrW'(k);
            if (((PtrW + 1)'(k) < count_q) && (mem_q[idx].addr[31:2] == cmp_word)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign hit_entry  = mem_q[hit_idx];
    assign full       = (count_q == (PtrW + 1)'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between CPU and data memory; loads bypass pending drains unless they
// hit a pending store. Define STORE_BUF_FWD_EN to forward word stores to word loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    sb_state_e       state_q, state_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            push, pop, full, empty, hit, fwd_hit;
    logic            issue_wr, issue_rd, stall_c;
    logic [PtrW-1:0] hit_idx;
    sb_entry_t       head_entry, hit_entry;

    store_buffer_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry('{addr: addr, data: write_data, mask: sign_mask}),
        .pop       (pop),
        .head_entry(head_entry),
        .full      (full),
        .empty     (empty),
        .cmp_word  (addr[31:2]),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .hit_entry (hit_entry)
    );

`ifdef STORE_BUF_FWD_EN
    // Only a whole-word store fully covers a word load.
    assign fwd_hit = hit && (hit_entry.mask[2:0] == SzWord) && (sign_mask[2:0] == SzWord);
    logic unused_fwd;
    assign unused_fwd = ^{hit_idx, hit_entry.addr, hit_entry.mask[3]};
`else
    assign fwd_hit = 1'b0;
    logic unused_fwd;
    assign unused_fwd = ^{hit_idx, hit_entry};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        pop         = 1'b0;
        stall_c     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (memread) begin
                    stall_c = 1'b1;
                    if (fwd_hit) begin
                        read_data_d = hit_entry.data;
                        state_d     = StLoadDone;
                    end else if (!hit && !mem_clk_stall) begin
                        issue_rd = 1'b1;
                        state_d  = StLoadWait;
                    end else if (!empty && !mem_clk_stall) begin
                        issue_wr = 1'b1;
                        state_d  = StDrainWait;
                    end
                end else if (!empty && !mem_clk_stall) begin
                    issue_wr = 1'b1;
                    state_d  = StDrainWait;
                end
            end
            StDrainWait: begin
                stall_c = memread;
                if (!mem_clk_stall) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            StLoadWait: begin
                stall_c = 1'b1;
                if (!mem_clk_stall) begin
                    read_data_d = mem_read_data;
                    state_d     = StLoadDone;
                end
            end
            StLoadDone: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // A full buffer accepts the store on the edge that pops the head.
        push = memwrite && (!full || pop);
        if (memwrite && !push) stall_c = 1'b1;
    end

    always_comb begin
        read_data      = read_data_q;
        clk_stall      = stall_c;
        mem_memwrite   = issue_wr;
        mem_memread    = issue_rd;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_sign_mask  = '0;
        if (issue_wr) begin
            mem_addr       = head_entry.addr;
            mem_write_data = head_entry.data;
            mem_sign_mask  = head_entry.mask;
        end else if (issue_rd) begin
            mem_addr      = addr;
            mem_sign_mask = sign_mask;
        end
        if (!rst_n) begin
            read_data    = '0;
            clk_stall    = 1'b0;
            mem_memwrite = 1'b0;
            mem_memread  = 1'b0;
            mem_addr     = '0;
            mem_write_data = '0;
            mem_sign_mask  = '0;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// checked against an architectural memory and an in-order drain queue.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, write_data, read_data, mem_addr, mem_write_data, mem_read_data;
    logic        memwrite, memread, clk_stall, mem_memwrite, mem_memread, mem_clk_stall;
    logic [3:0]  sign_mask, mem_sign_mask;

    store_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .write_data    (write_data),
        .memwrite      (memwrite),
        .memread       (memread),
        .sign_mask     (sign_mask),
        .read_data     (read_data),
        .clk_stall     (clk_stall),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_memwrite  (mem_memwrite),
        .mem_memread   (mem_memread),
        .mem_sign_mask (mem_sign_mask),
        .mem_read_data (mem_read_data),
        .mem_clk_stall (mem_clk_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_t;

    st_t        wq[$];                 // stores accepted but not yet sent downstream
    logic [7:0] dmem[logic [31:0]];    // downstream memory contents
    logic [7:0] amem[logic [31:0]];    // architectural (program-order) memory
    int vectors = 0;
    int miscompares = 0;
    int out_kind = 0;                  // 0 none, 1 store, 2 load outstanding downstream
    int wr_pulses = 0;
    int rd_pulses = 0;
    bit ms_rand = 0;
    logic ms_force = 1'b0;
    bit st_seen, last_rd_issue, last_wr_issue;
    logic [31:0] rd_seen;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(logic [2:0] sz);
        return (sz == SzByte) ? 1 : (sz == SzHalf) ? 2 : 4;
    endfunction

    function automatic void mem_wr(bit arch, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        for (int i = 0; i < nbytes(m[2:0]); i++) begin
            if (arch) amem[a + 32'(i)] = d[8*i +: 8];
            else dmem[a + 32'(i)] = d[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] mem_rd(bit arch, logic [31:0] a, logic [3:0] m);
        logic [31:0] v;
        logic [31:0] ba;
        logic [7:0]  b;
        int n;
        v = '0;
        n = nbytes(m[2:0]);
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if (arch) b = amem.exists(ba) ? amem[ba] : 8'h00;
            else b = dmem.exists(ba) ? dmem[ba] : 8'h00;
            v[8*i +: 8] = b;
        end
        if (m[3] && n < 4) for (int i = 8 * n; i < 32; i++) v[i] = v[8*n-1];
        return v;
    endfunction

    // One clock cycle: inputs already driven; observe, model downstream, advance.
    task automatic cycle();
        int  occ, prev_kind;
        bit  done_out, issued, hz;
        mem_clk_stall = ms_rand ? ($urandom_range(0, 2) == 0) : ms_force;
        #1;
        prev_kind = out_kind;
        occ = wq.size() + ((out_kind == 1) ? 1 : 0);
        done_out = (out_kind != 0) && !mem_clk_stall;
        st_seen = clk_stall;
        rd_seen = read_data;
        last_rd_issue = mem_memread;
        last_wr_issue = mem_memwrite;
        issued = mem_memwrite || mem_memread;
        if (issued)
            check("issue_protocol", {mem_clk_stall, out_kind != 0, mem_memwrite & mem_memread}, 0);
        if (mem_memwrite) begin
            wr_pulses++;
            if (wq.size() == 0) check("drain_unexpected", mem_memwrite, 1'b0);
            else begin
                check("drain_entry", {mem_addr, mem_write_data, mem_sign_mask},
                      {wq[0].addr, wq[0].data, wq[0].mask});
                mem_wr(0, wq[0].addr, wq[0].data, wq[0].mask);
                void'(wq.pop_front());
            end
            out_kind = 1;
        end
        if (mem_memread) begin
            rd_pulses++;
            hz = 0;
            foreach (wq[i]) if (wq[i].addr[31:2] == mem_addr[31:2]) hz = 1;
            check("load_hazard_clear", hz, 1'b0);
            check("load_request", {mem_addr, mem_sign_mask}, {addr, sign_mask});
            mem_read_data = mem_rd(0, mem_addr, mem_sign_mask);
            out_kind = 2;
        end
        if (memwrite) begin
            check("store_stall", clk_stall,
                  (occ == int'(DEPTH)) && !(done_out && prev_kind == 1));
            if (!clk_stall) begin
                mem_wr(1, addr, write_data, sign_mask);
                wq.push_back('{addr, write_data, sign_mask});
            end
        end
        @(posedge clk);
        if (done_out && !issued) out_kind = 0;
        @(negedge clk);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            output int stalls);
        addr = a; write_data = d; sign_mask = m; memwrite = 1'b1; memread = 1'b0;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!st_seen) break;
            stalls++;
        end
        memwrite = 1'b0;
        check("store_completes", st_seen, 1'b0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] m, output int stalls,
                           output int rd_ops, output bit first_rd);
        int rd0;
        addr = a; sign_mask = m; write_data = '0; memread = 1'b1; memwrite = 1'b0;
        stalls = 0;
        first_rd = 0;
        rd0 = rd_pulses;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (i == 0) first_rd = last_rd_issue;
            if (!st_seen) break;
            stalls++;
        end
        memread = 1'b0;
        rd_ops = rd_pulses - rd0;
        check("load_completes", st_seen, 1'b0);
        check("load_data", rd_seen, mem_rd(1, a, m));
        check("load_single_issue", rd_ops <= 1, 1'b1);
    endtask

    task automatic idle(input int n);
        memwrite = 1'b0; memread = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain_all();
        memwrite = 1'b0; memread = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (wq.size() == 0 && out_kind == 0) break;
            cycle();
        end
        check("drain_finishes", wq.size() + out_kind, 0);
    endtask

    initial begin
        int s, r, w0, op;
        bit f;
        logic [31:0] a;
        logic [2:0] sz;

        rst_n = 1'b0; memwrite = 1'b0; memread = 1'b0; addr = '0; write_data = '0;
        sign_mask = '0; mem_read_data = '0; mem_clk_stall = 1'b0;
        #1;
        check("reset_outputs", {read_data, clk_stall, mem_addr, mem_write_data, mem_memwrite,
                                mem_memread, mem_sign_mask}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Four back-to-back word stores, downstream free.
        ms_rand = 0; ms_force = 1'b0; w0 = wr_pulses;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), {1'b0, SzWord}, s);
            check("burst_no_stall", s, 0);
        end
        drain_all();
        check("burst_drains", wr_pulses - w0, 4);

        // Fill while downstream busy, then a fifth store must wait for a drain.
        ms_force = 1'b1; w0 = wr_pulses;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h1100 + 32'(4 * i), 32'hB000_0000 + 32'(i), {1'b0, SzWord}, s);
            check("fill_no_stall", s, 0);
        end
        ms_rand = 1;
        do_store(32'h1110, 32'hB000_0004, {1'b0, SzWord}, s);
        check("full_store_stalls", s > 0, 1'b1);
        drain_all();
        check("five_drains", wr_pulses - w0, 5);

        // Non-hazard load overtakes a pending drain.
        ms_rand = 0; ms_force = 1'b0;
        mem_wr(0, 32'h1008, 32'hCAFE_F00D, {1'b0, SzWord});
        mem_wr(1, 32'h1008, 32'hCAFE_F00D, {1'b0, SzWord});
        do_store(32'h1004, 32'h1111_2222, {1'b0, SzWord}, s);
        do_load(32'h1008, {1'b0, SzWord}, s, r, f);
        check("bypass_first_op_is_load", f, 1'b1);
        check("bypass_stall_cycles", s, 2);
        check("bypass_data", rd_seen, 32'hCAFE_F00D);
        drain_all();

        // Word store then word load to the same word.
        do_store(32'h1010, 32'hDEAD_BEEF, {1'b0, SzWord}, s);
        do_load(32'h1010, {1'b0, SzWord}, s, r, f);
        check("hazard_word_data", rd_seen, 32'hDEAD_BEEF);
`ifdef STORE_BUF_FWD_EN
        check("fwd_stall_cycles", s, 1);
        check("fwd_no_memread", r, 0);
`else
        check("hazard_load_issued", r, 1);
`endif

        // Byte store into that word forces a drain before the load.
        do_store(32'h1011, 32'h0000_007F, {1'b0, SzByte}, s);
        do_load(32'h1010, {1'b0, SzWord}, s, r, f);
        check("merge_word", rd_seen, 32'hDEAD_7FEF);
        check("merge_load_issued", r, 1);
        drain_all();

        // Randomized mix over a small window to provoke hazards and back-pressure.
        ms_rand = 1;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0: sz = SzByte;
                1: sz = SzHalf;
                default: sz = SzWord;
            endcase
            a = 32'h2000 + 32'($urandom_range(0, 15));
            a = a & ~(32'(nbytes(sz)) - 32'd1);
            if (op < 5) do_store(a, $urandom, {1'b0, sz}, s);
            else if (op < 8) do_load(a, {1'($urandom_range(0, 1)), sz}, s, r, f);
            else idle(1);
        end
        ms_rand = 0; ms_force = 1'b0;
        drain_all();

        // Reset in the middle of a drain with three entries queued.
        ms_force = 1'b1;
        do_store(32'h3000, 32'h0000_000A, {1'b0, SzWord}, s);
        do_store(32'h3004, 32'h0000_000B, {1'b0, SzWord}, s);
        do_store(32'h3008, 32'h0000_000C, {1'b0, SzWord}, s);
        ms_force = 1'b0;
        idle(1);
        check("drain_issued_before_reset", last_wr_issue, 1'b1);
        ms_force = 1'b1;
        idle(1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_drain_outputs", {read_data, clk_stall, mem_addr, mem_write_data,
                                          mem_memwrite, mem_memread, mem_sign_mask}, 0);
        wq.delete();
        out_kind = 0;
        amem = dmem;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        ms_force = 1'b0;
        w0 = wr_pulses;
        idle(8);
        check("no_drain_after_reset", wr_pulses - w0, 0);
        do_store(32'h3010, 32'h0000_0010, {1'b0, SzWord}, s);
        check("first_store_after_reset", s, 0);
        do_load(32'h3004, {1'b0, SzWord}, s, r, f);
        check("discarded_store_lost", rd_seen, 32'h0);
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
